// File: rtl/codec_config_seq.sv
`default_nettype none
// ============================================================================
//  Module   : codec_config_seq
//  Purpose  : Power-up register loader for the WM8731 audio codec. On a start
//             pulse it writes an 11-entry init table over the 2-wire control
//             port. Each word is sent as one 3-byte frame:
//             {DEV_ADDR,W}, {reg[6:0],data[8]}, data[7:0].
//             A NACKed frame is retried up to RETRY_MAX times before error.
//  Ports    : clk          system clock
//             rst_n        asynchronous active-low reset
//             start        one-cycle pulse, accepted only while not busy
//             busy         sequence in progress
//             done         sticky: all words acknowledged
//             error        sticky: retries exhausted on some word
//             cur_index    table index in flight / last attempted
//             i2c_sclk     SCLK, push-pull, idles high
//             i2c_sdat_oe  1 = pull SDAT low, 0 = release
//             i2c_sdat_i   SDAT pad input (asynchronous)
//  Revision : 1.0  initial release
// ============================================================================
module codec_config_seq #(
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         I2C_HZ    = 100_000,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         RETRY_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] cur_index,
    output logic       i2c_sclk,
    output logic       i2c_sdat_oe,
    input  logic       i2c_sdat_i
);

    localparam int         DIV        = CLK_HZ / (4 * I2C_HZ);
    localparam int         CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int         RETRY_W    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [3:0] LAST_INDEX = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6,
        ST_FAIL  = 3'd7
    } state_t;

    function automatic logic [15:0] init_word(input logic [3:0] idx);
        case (idx)
            4'd0:    init_word = 16'h1E00;
            4'd1:    init_word = 16'h0017;
            4'd2:    init_word = 16'h0217;
            4'd3:    init_word = 16'h0479;
            4'd4:    init_word = 16'h0679;
            4'd5:    init_word = 16'h0812;
            4'd6:    init_word = 16'h0A00;
            4'd7:    init_word = 16'h0C00;
            4'd8:    init_word = 16'h0E01;
            4'd9:    init_word = 16'h1000;
            4'd10:   init_word = 16'h1201;
            default: init_word = 16'h0000;
        endcase
    endfunction

    state_t             state_q;
    logic [CNT_W-1:0]   tick_cnt_q;
    logic [1:0]         qtr_q;
    logic [2:0]         bit_cnt_q;
    logic [1:0]         byte_cnt_q;
    logic [RETRY_W-1:0] retry_q;
    logic [3:0]         index_q;
    logic               nack_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               sclk_q;
    logic               oe_q;
    logic [1:0]         sync_q;

    logic               w_accept;
    logic               w_tick;
    logic [15:0]        w_word;
    logic [7:0]         w_byte;
    logic               w_cur_bit;

    // Start is honoured only in the non-busy states.
    assign w_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_FAIL));
    assign w_tick   = (tick_cnt_q == CNT_W'(DIV - 1));
    assign w_word   = init_word(index_q);
    assign w_byte   = (byte_cnt_q == 2'd0) ? {DEV_ADDR, 1'b0} :
                      (byte_cnt_q == 2'd1) ? w_word[15:8] : w_word[7:0];
    assign w_cur_bit = w_byte[3'd7 - bit_cnt_q];

    // Quarter-bit tick generator; realigned on start so the first bus edge
    // lands exactly DIV clocks after the accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (w_accept || w_tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

    // Two-flop synchroniser for the open-drain SDAT pad (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i2c_sdat_i};
        end
    end

    // Sequencer. Every bus-visible change happens on a tick; qtr_q walks the
    // four quarters of the current cell and wraps to 0 on entry to each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            qtr_q      <= 2'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            retry_q    <= '0;
            index_q    <= 4'd0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            sclk_q     <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (w_accept) begin
                        state_q    <= ST_START;
                        qtr_q      <= 2'd0;
                        bit_cnt_q  <= 3'd0;
                        byte_cnt_q <= 2'd0;
                        retry_q    <= '0;
                        index_q    <= 4'd0;
                        nack_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    if (w_tick) begin
                        qtr_q <= qtr_q + 2'd1;
                        case (state_q)
                            ST_START: begin
                                // SDAT falls while SCLK is still high.
                                if (qtr_q == 2'd0) begin
                                    oe_q <= 1'b1;
                                end else if (qtr_q == 2'd3) begin
                                    sclk_q     <= 1'b0;
                                    bit_cnt_q  <= 3'd0;
                                    byte_cnt_q <= 2'd0;
                                    state_q    <= ST_BIT;
                                end
                            end
                            ST_BIT: begin
                                case (qtr_q)
                                    2'd0: oe_q   <= ~w_cur_bit;
                                    2'd1: sclk_q <= 1'b1;
                                    2'd3: begin
                                        sclk_q    <= 1'b0;
                                        bit_cnt_q <= bit_cnt_q + 3'd1;
                                        if (bit_cnt_q == 3'd7) begin
                                            state_q <= ST_ACK;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            ST_ACK: begin
                                case (qtr_q)
                                    2'd0: oe_q   <= 1'b0;
                                    2'd1: sclk_q <= 1'b1;
                                    2'd2: nack_q <= sync_q[1];
                                    2'd3: begin
                                        sclk_q <= 1'b0;
                                        // A NACK on any byte abandons the frame.
                                        if (nack_q || (byte_cnt_q == 2'd2)) begin
                                            state_q <= ST_STOP;
                                        end else begin
                                            byte_cnt_q <= byte_cnt_q + 2'd1;
                                            state_q    <= ST_BIT;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            ST_STOP: begin
                                // SDAT is released while SCLK is high.
                                case (qtr_q)
                                    2'd0: oe_q   <= 1'b1;
                                    2'd1: sclk_q <= 1'b1;
                                    2'd3: begin
                                        oe_q    <= 1'b0;
                                        state_q <= ST_GAP;
                                    end
                                    default: ;
                                endcase
                            end
                            ST_GAP: begin
                                if (qtr_q == 2'd3) begin
                                    if (nack_q) begin
                                        if (retry_q == RETRY_W'(RETRY_MAX)) begin
                                            busy_q  <= 1'b0;
                                            error_q <= 1'b1;
                                            state_q <= ST_FAIL;
                                        end else begin
                                            retry_q <= retry_q + RETRY_W'(1);
                                            nack_q  <= 1'b0;
                                            state_q <= ST_START;
                                        end
                                    end else if (index_q == LAST_INDEX) begin
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                        state_q <= ST_DONE;
                                    end else begin
                                        index_q <= index_q + 4'd1;
                                        retry_q <= '0;
                                        state_q <= ST_START;
                                    end
                                end
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cur_index   = index_q;
    assign i2c_sclk    = sclk_q;
    assign i2c_sdat_oe = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_codec_config_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_codec_config_seq
//  Purpose  : Self-checking bench for codec_config_seq with a 2-wire slave
//             model that captures frames and answers ACK/NACK by policy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_codec_config_seq;

    localparam int CLK_HZ    = 2_000_000;
    localparam int I2C_HZ    = 100_000;
    localparam int DIV       = CLK_HZ / (4 * I2C_HZ);
    localparam int CELL      = 4 * DIV;
    localparam int BOUND     = 40000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [3:0] cur_index;
    logic       i2c_sclk, i2c_sdat_oe;
    logic       sda_line;
    logic       slave_pull = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] tbl [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                16'h0812, 16'h0A00, 16'h0C00, 16'h0E01, 16'h1000,
                                16'h1201};

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    // slave model state
    int          mode        = 0;  // 0 ack all, 1 nack address, 2 nack index 3 once
    bit          nacked_once = 0;
    bit          model_clear = 0;
    logic        prev_sclk   = 1'b1;
    logic        prev_sda    = 1'b1;
    bit          in_frame    = 0;
    bit          in_ack      = 0;
    int          bitcnt      = 0;
    int          bytecnt     = 0;
    logic [7:0]  shreg       = 8'h00;
    logic [23:0] fbytes      = 24'h0;
    int          cyc         = 0;
    int          stop_cyc    = 0;
    int          fall_cyc    = 0;
    bit          rise_seen   = 0;
    int          rise_cyc    = 0;
    int          timing_err  = 0;

    assign sda_line = ~(i2c_sdat_oe | slave_pull);

    codec_config_seq #(
        .CLK_HZ   (CLK_HZ),
        .I2C_HZ   (I2C_HZ),
        .DEV_ADDR (7'h1A),
        .RETRY_MAX(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cur_index  (cur_index),
        .i2c_sclk   (i2c_sclk),
        .i2c_sdat_oe(i2c_sdat_oe),
        .i2c_sdat_i (sda_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_frame(input int idx, input int n);
        logic [23:0] b;
        b = {8'h34, tbl[idx]};
        if (n < 3) b[7:0]  = 8'h00;
        if (n < 2) b[15:8] = 8'h00;
        return {6'd0, 2'(n), b};
    endfunction

    // Slave/monitor: evaluated on the falling clock edge, away from DUT updates.
    always @(negedge clk) begin : slave_model
        logic sda;
        logic ack;
        sda = sda_line;
        if (model_clear) begin
            in_frame = 0; in_ack = 0; slave_pull = 1'b0;
            bitcnt = 0; bytecnt = 0; rise_seen = 0; model_clear = 0;
        end else if (prev_sclk && i2c_sclk && prev_sda && !sda) begin
            in_frame = 1; in_ack = 0; bitcnt = 0; bytecnt = 0;
            fbytes = 24'h0; rise_seen = 0;
        end else if (prev_sclk && i2c_sclk && !prev_sda && sda) begin
            if (in_frame) begin
                obs_q.push_back({6'd0, 2'(bytecnt), fbytes});
                stop_cyc = cyc;
            end
            in_frame = 0; in_ack = 0; slave_pull = 1'b0; rise_seen = 0;
        end else if (in_frame && !prev_sclk && i2c_sclk) begin
            if (rise_seen && (cyc - rise_cyc) != CELL) timing_err++;
            rise_seen = 1;
            rise_cyc  = cyc;
            if (!in_ack && bitcnt < 8) begin
                shreg = {shreg[6:0], sda};
                bitcnt++;
            end
        end else if (in_frame && prev_sclk && !i2c_sclk) begin
            if (rise_seen && (cyc - rise_cyc) != 2 * DIV) timing_err++;
            if (in_ack) begin
                slave_pull = 1'b0; in_ack = 0; bitcnt = 0;
            end else if (bitcnt == 8) begin
                if (bytecnt < 3) fbytes[8*(2-bytecnt) +: 8] = shreg;
                ack = 1'b1;
                if (mode == 1 && bytecnt == 0) ack = 1'b0;
                if (mode == 2 && bytecnt == 1 && shreg == 8'h04 && !nacked_once) begin
                    ack = 1'b0;
                    nacked_once = 1;
                end
                slave_pull = ack;
                bytecnt++;
                in_ack = 1;
            end
        end
        prev_sclk = i2c_sclk;
        prev_sda  = sda_line;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_not_busy(output bit to);
        int n = 0;
        while (busy === 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        to       = (busy !== 1'b0);
        fall_cyc = cyc;
    endtask

    task automatic clear_model();
        model_clear = 1;
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        timing_err = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, error, cur_index, i2c_sclk, i2c_sdat_oe} !== 9'b0_0_0_0000_1_0) begin
            tests_failed++;
            $display("FAIL reset_hold: got %b expected %b",
                     {busy, done, error, cur_index, i2c_sclk, i2c_sdat_oe}, 9'b0_0_0_0000_1_0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, error, cur_index, i2c_sclk, i2c_sdat_oe} !== 9'b0_0_0_0000_1_0) begin
            tests_failed++;
            $display("FAIL reset_release: got %b expected %b",
                     {busy, done, error, cur_index, i2c_sclk, i2c_sdat_oe}, 9'b0_0_0_0000_1_0);
        end
    endtask

    task automatic test_nominal();
        int lat;
        int k;
        bit to;
        logic [31:0] e, o;
        mode = 0;
        clear_model();
        for (int i = 0; i <= 10; i++) exp_q.push_back(exp_frame(i, 3));
        pulse_start();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL nominal_busy: got %b expected 1", busy);
        end
        lat = 0;
        while (i2c_sdat_oe !== 1'b1 && lat < 10 * DIV) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (lat != DIV) begin
            tests_failed++;
            $display("FAIL nominal_latency: got %0d clks expected %0d", lat, DIV);
        end
        wait_not_busy(to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL nominal_timeout: busy=%b expected 0", busy);
        end
        tests_run++;
        if ({done, error, cur_index} !== {1'b1, 1'b0, 4'd10}) begin
            tests_failed++;
            $display("FAIL nominal_flags: got done=%b error=%b idx=%0d expected 1 0 10",
                     done, error, cur_index);
        end
        tests_run++;
        if (fall_cyc - stop_cyc != CELL) begin
            tests_failed++;
            $display("FAIL nominal_gap: got %0d clks expected %0d", fall_cyc - stop_cyc, CELL);
        end
        tests_run++;
        if (timing_err != 0) begin
            tests_failed++;
            $display("FAIL nominal_sclk_timing: got %0d errors expected 0", timing_err);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL nominal_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL nominal_frame%0d: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_single_nack();
        int k;
        bit to;
        logic [31:0] e, o;
        mode = 2;
        nacked_once = 0;
        clear_model();
        for (int i = 0; i <= 10; i++) begin
            if (i == 3) exp_q.push_back(exp_frame(3, 2));
            exp_q.push_back(exp_frame(i, 3));
        end
        pulse_start();
        wait_not_busy(to);
        tests_run++;
        if (to || {done, error, cur_index} !== {1'b1, 1'b0, 4'd10}) begin
            tests_failed++;
            $display("FAIL single_nack_flags: got to=%b done=%b error=%b idx=%0d expected 0 1 0 10",
                     to, done, error, cur_index);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL single_nack_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL single_nack_frame%0d: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_persistent_nack();
        int k;
        bit to;
        logic [31:0] e, o;
        mode = 1;
        clear_model();
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_frame(0, 1));
        pulse_start();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL persist_done_clear: got %b expected 0", done);
        end
        wait_not_busy(to);
        tests_run++;
        if (to || {done, error, cur_index} !== {1'b0, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL persist_flags: got to=%b done=%b error=%b idx=%0d expected 0 0 1 0",
                     to, done, error, cur_index);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL persist_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL persist_frame%0d: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int k;
        bit to;
        logic [31:0] e, o;
        mode = 0;
        clear_model();
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_frame(i, 3));
        pulse_start();
        n = 0;
        while (!(cur_index == 4'd5 && bytecnt == 1 && bitcnt == 4) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= BOUND) begin
            tests_failed++;
            $display("FAIL reset_mid_reach: got idx=%0d expected 5", cur_index);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, error, cur_index, i2c_sclk, i2c_sdat_oe} !== 9'b0_0_0_0000_1_0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got %b expected %b",
                     {busy, done, error, cur_index, i2c_sclk, i2c_sdat_oe}, 9'b0_0_0_0000_1_0);
        end
        tests_run++;
        if (obs_q.size() != 5) begin
            tests_failed++;
            $display("FAIL reset_mid_count: got %0d frames expected 5", obs_q.size());
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_frame%0d: got %h expected %h", k, o, e);
            end
            k++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        for (int i = 0; i <= 10; i++) exp_q.push_back(exp_frame(i, 3));
        pulse_start();
        wait_not_busy(to);
        tests_run++;
        if (to || {done, error, cur_index} !== {1'b1, 1'b0, 4'd10}) begin
            tests_failed++;
            $display("FAIL reset_mid_replay_flags: got to=%b done=%b error=%b idx=%0d expected 0 1 0 10",
                     to, done, error, cur_index);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL reset_mid_replay_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_replay_frame%0d: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int k;
        logic [31:0] e, o;
        mode = 0;
        clear_model();
        for (int i = 0; i <= 10; i++) exp_q.push_back(exp_frame(i, 3));
        pulse_start();
        repeat (3 * CELL) @(negedge clk);
        pulse_start();
        tests_run++;
        if ({busy, cur_index} !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL b2b_early_start: got busy=%b idx=%0d expected 1 0", busy, cur_index);
        end
        n = 0;
        while (cur_index != 4'd5 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        pulse_start();
        tests_run++;
        if ({busy, cur_index} !== {1'b1, 4'd5}) begin
            tests_failed++;
            $display("FAIL b2b_mid_start: got busy=%b idx=%0d expected 1 5", busy, cur_index);
        end
        n = 0;
        while (obs_q.size() < 11 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        // Hold start high across the clock edge on which DONE is entered.
        n = 0;
        while (cyc < stop_cyc + CELL - 1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({busy, done} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_done_edge: got busy=%b done=%b expected 0 1", busy, done);
        end
        repeat (2 * CELL) @(negedge clk);
        tests_run++;
        if ({busy, done, error} !== 3'b010) begin
            tests_failed++;
            $display("FAIL b2b_no_restart: got busy=%b done=%b error=%b expected 0 1 0",
                     busy, done, error);
        end
        tests_run++;
        if (obs_q.size() != 11) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d frames expected 11", obs_q.size());
        end
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL b2b_frame%0d: got %h expected %h", k, o, e);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_single_nack();
        test_persistent_nack();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
